alu_control_seq: RTL and testbench
==================================

Name: alu_control_seq

Overview:
- Parametrised, sequenced successor to the combinational ALU control decoder.
- Accepts one {alu_op, funct, shamt} command per handshake and emits a registered stream of ALU control codes, one per cycle.
- Multi-bit rotates (ROL/ROR by shamt) expand into shamt consecutive 1-bit rotate steps on the existing single-bit-rotate ALU.
- Sits between the main control unit/decode stage and the ALU in the multi-cycle datapath.

Parameters:
- CTL_W, 3, width of alu_ctl code (must be >= 3).
- FUNCT_W, 6, width of funct field.
- SHAMT_W, 5, width of rotate amount; max steps per command = 2^SHAMT_W - 1.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  command present.
- in_ready  output  1  block can accept a command this cycle (combinational from state).
- alu_op  input  2  00 = LW/SW, 01 = BEQ, 1x = R-type.
- funct  input  FUNCT_W  R-type function code.
- shamt  input  SHAMT_W  rotate amount; ignored for non-rotates.
- alu_ctl  output  CTL_W  registered ALU control code.
- ctl_valid  output  1  alu_ctl valid this cycle.
- last  output  1  final step of the current command.
- illegal  output  1  current step comes from an undefined R-type funct.
- busy  output  1  a command is in progress (state RUN).

Behaviour:
- Reset (async, immediate): state IDLE, cnt 0, alu_ctl 0, ctl_valid 0, last 0, illegal 0, busy 0. in_ready is then 1.
- Reset mid-sequence aborts with no further pulses.
- Codes, zero-extended to CTL_W:
  - AND 000, OR 001, ADD 010, PASS 011, ROL 100, ROR 101, SUB 110.
- Decode:
  - alu_op 00 -> ADD.
  - alu_op 01 -> SUB.
  - alu_op 1x with funct 100000 -> ADD, 100001 -> ROL, 100010 -> SUB, 100011 -> ROR, 100100 -> AND, 100101 -> OR.
  - Any other funct -> PASS with illegal = 1.
- Step count:
  - Rotates: shamt.
  - All other commands: 1.
  - Rotate with shamt = 0 -> one step, code PASS, illegal = 0.
- Accept occurs on any edge with in_valid && in_ready.
- Latency: accept at edge N -> first alu_ctl/ctl_valid visible after edge N, i.e. one cycle.
- FSM:
  - IDLE: ctl_valid = 0.
    - On accept -> RUN, cnt = steps, outputs show first step.
  - RUN: ctl_valid = 1, busy = 1, alu_ctl constant for the whole command.
    - Each edge decrements cnt.
    - last = (cnt == 1).
    - Leaving the last step: with no accept -> IDLE; with accept -> stay in RUN and load the new command (back-to-back, no bubble).
- in_ready = (state == IDLE) || (state == RUN && cnt == 1).
- Inputs are ignored unless accepted; later changes do not affect a running command.
- Max rotate (shamt = 2^SHAMT_W - 1) runs exactly that many cycles; cnt never wraps.
- illegal is valid only while ctl_valid is 1; otherwise it is 0.

Optional Feature:
- Macro: ALU_CTL_SEQ_FLUSH_EN.
- With the macro defined:
  - Adds input port flush (1 bit).
  - While flush = 1, in_ready is forced 0.
  - At the next edge: state -> IDLE, cnt -> 0, ctl_valid/last/illegal/busy -> 0. Flush has priority over accept and step decrement.
  - A flush in IDLE has no effect.
- Without the macro: no flush port; every command runs to completion.

Test Plan:
- Reset release, in_valid = 0 -> in_ready = 1, ctl_valid = 0, alu_ctl = 000, busy = 0 indefinitely.
- alu_op = 00 accepted at edge N -> after N: alu_ctl = 010, ctl_valid = 1, last = 1, one cycle; IDLE after N+1.
- alu_op = 10, funct = 100001, shamt = 5 -> five consecutive cycles of alu_ctl = 100; last high only on the 5th; in_ready low for cycles 1-4, high on cycle 5.
- Back-to-back: ROR shamt = 2, then BEQ held valid -> pulses 101, 101, 110 with no gap; last on the 2nd and 3rd.
- alu_op = 11, funct = 111111 -> one pulse alu_ctl = 011, illegal = 1, last = 1. ROL with shamt = 0 -> one pulse 011, illegal = 0.
- rst asserted on the 3rd step of ROL shamt = 31 -> outputs zero immediately, no further pulses. With ALU_CTL_SEQ_FLUSH_EN, the same case with flush instead of rst -> IDLE at the next edge, and a new command is accepted the cycle after.

Source files
------------

// File: rtl/alu_control_seq.sv
// alu_control_seq: sequenced ALU control decoder. Accepts one
// {alu_op, funct, shamt} command per valid/ready handshake and emits
// a registered stream of ALU control codes, one per cycle. Multi-bit
// rotates expand into shamt single-bit rotate steps.
// Ports: clk, rst (async, active-high), in_valid/in_ready handshake,
// alu_op/funct/shamt command, alu_ctl/ctl_valid/last/illegal/busy out.
// Optional: define ALU_CTL_SEQ_FLUSH_EN to add a flush input that
// aborts the running command at the next edge.
module alu_control_seq #(
  parameter int CTL_W   = 3,
  parameter int FUNCT_W = 6,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
`ifdef ALU_CTL_SEQ_FLUSH_EN
  input  logic               flush,
`endif
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         alu_op,
  input  logic [FUNCT_W-1:0] funct,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [CTL_W-1:0]   alu_ctl,
  output logic               ctl_valid,
  output logic               last,
  output logic               illegal,
  output logic               busy
);

  localparam logic [CTL_W-1:0] C_AND  = CTL_W'(3'b000);
  localparam logic [CTL_W-1:0] C_OR   = CTL_W'(3'b001);
  localparam logic [CTL_W-1:0] C_ADD  = CTL_W'(3'b010);
  localparam logic [CTL_W-1:0] C_PASS = CTL_W'(3'b011);
  localparam logic [CTL_W-1:0] C_ROL  = CTL_W'(3'b100);
  localparam logic [CTL_W-1:0] C_ROR  = CTL_W'(3'b101);
  localparam logic [CTL_W-1:0] C_SUB  = CTL_W'(3'b110);

  localparam logic [FUNCT_W-1:0] F_ADD = FUNCT_W'(6'b100000);
  localparam logic [FUNCT_W-1:0] F_ROL = FUNCT_W'(6'b100001);
  localparam logic [FUNCT_W-1:0] F_SUB = FUNCT_W'(6'b100010);
  localparam logic [FUNCT_W-1:0] F_ROR = FUNCT_W'(6'b100011);
  localparam logic [FUNCT_W-1:0] F_AND = FUNCT_W'(6'b100100);
  localparam logic [FUNCT_W-1:0] F_OR  = FUNCT_W'(6'b100101);

  localparam logic [SHAMT_W-1:0] ONE = SHAMT_W'(1);
  localparam logic [SHAMT_W-1:0] TWO = SHAMT_W'(2);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_e;

  state_e             state_q, state_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [CTL_W-1:0]   alu_ctl_q, alu_ctl_d;
  logic               ctl_valid_q, ctl_valid_d;
  logic               last_q, last_d;
  logic               illegal_q, illegal_d;
  logic               busy_q, busy_d;

  logic [CTL_W-1:0]   dec_code;
  logic               dec_ill;
  logic               dec_rot;
  logic [SHAMT_W-1:0] dec_steps;
  logic               do_flush;
  logic               accept;

`ifdef ALU_CTL_SEQ_FLUSH_EN
  assign do_flush = flush;
`else
  assign do_flush = 1'b0;
`endif

  // Ready while idle, or on the final step so the next command
  // follows with no bubble.
  assign in_ready = !do_flush &&
                    (state_q == S_IDLE || cnt_q == ONE);
  assign accept = in_valid && in_ready;

  always_comb begin
    dec_code = C_ADD;
    dec_ill  = 1'b0;
    dec_rot  = 1'b0;
    unique case (1'b1)
      alu_op == 2'b00: dec_code = C_ADD;
      alu_op == 2'b01: dec_code = C_SUB;
      default: begin
        unique case (funct)
          F_ADD: dec_code = C_ADD;
          F_ROL: begin
            dec_code = C_ROL;
            dec_rot  = 1'b1;
          end
          F_SUB: dec_code = C_SUB;
          F_ROR: begin
            dec_code = C_ROR;
            dec_rot  = 1'b1;
          end
          F_AND: dec_code = C_AND;
          F_OR:  dec_code = C_OR;
          default: begin
            dec_code = C_PASS;
            dec_ill  = 1'b1;
          end
        endcase
      end
    endcase
    // A zero-length rotate still occupies one step as a PASS.
    dec_steps = ONE;
    if (dec_rot) begin
      if (shamt == '0) begin
        dec_code = C_PASS;
      end else begin
        dec_steps = shamt;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_ctl_d   = alu_ctl_q;
    ctl_valid_d = ctl_valid_q;
    last_d      = last_q;
    illegal_d   = illegal_q;
    busy_d      = busy_q;
    if (do_flush || (!accept && state_q == S_RUN &&
                     cnt_q == ONE)) begin
      state_d     = S_IDLE;
      cnt_d       = '0;
      alu_ctl_d   = '0;
      ctl_valid_d = 1'b0;
      last_d      = 1'b0;
      illegal_d   = 1'b0;
      busy_d      = 1'b0;
    end else if (accept) begin
      state_d     = S_RUN;
      cnt_d       = dec_steps;
      alu_ctl_d   = dec_code;
      ctl_valid_d = 1'b1;
      last_d      = (dec_steps == ONE);
      illegal_d   = dec_ill;
      busy_d      = 1'b1;
    end else if (state_q == S_RUN) begin
      cnt_d  = cnt_q - ONE;
      last_d = (cnt_q == TWO);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      alu_ctl_q   <= '0;
      ctl_valid_q <= 1'b0;
      last_q      <= 1'b0;
      illegal_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_ctl_q   <= alu_ctl_d;
      ctl_valid_q <= ctl_valid_d;
      last_q      <= last_d;
      illegal_q   <= illegal_d;
      busy_q      <= busy_d;
    end
  end

  assign alu_ctl   = alu_ctl_q;
  assign ctl_valid = ctl_valid_q;
  assign last      = last_q;
  assign illegal   = illegal_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_alu_control_seq.sv
// tb_alu_control_seq: directed plus random stimulus for alu_control_seq,
// checked against a pulse-queue reference model.
module tb_alu_control_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush_v = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] alu_op = '0;
  logic [5:0] funct = '0;
  logic [4:0] shamt = '0;
  logic [2:0] alu_ctl;
  logic       ctl_valid, last, illegal, busy;

  int pass_cnt = 0;
  int total = 0;

  typedef struct {
    logic [2:0] code;
    bit         ill;
    bit         lst;
  } pulse_t;

  pulse_t q[$];

  always #5 clk = ~clk;

  alu_control_seq dut (
    .clk(clk),
    .rst(rst),
`ifdef ALU_CTL_SEQ_FLUSH_EN
    .flush(flush_v),
`endif
    .in_valid(in_valid),
    .in_ready(in_ready),
    .alu_op(alu_op),
    .funct(funct),
    .shamt(shamt),
    .alu_ctl(alu_ctl),
    .ctl_valid(ctl_valid),
    .last(last),
    .illegal(illegal),
    .busy(busy)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h t=%0t",
                tag, obs, exp, $time);
  endtask

  function automatic bit exp_ready();
`ifdef ALU_CTL_SEQ_FLUSH_EN
    if (flush_v) return 1'b0;
`endif
    return q.size() <= 1;
  endfunction

  // Expected pulse train of a command, from the decode table.
  task automatic push_cmd(logic [1:0] op, logic [5:0] f,
                          logic [4:0] sh);
    logic [2:0] code;
    bit ill;
    int n;
    n = 1;
    ill = 0;
    if (op == 2'b00) code = 3'd2;
    else if (op == 2'b01) code = 3'd6;
    else begin
      case (f)
        6'd32: code = 3'd2;
        6'd33: begin code = (sh == 0) ? 3'd3 : 3'd4; n = (sh == 0) ? 1 : sh; end
        6'd34: code = 3'd6;
        6'd35: begin code = (sh == 0) ? 3'd3 : 3'd5; n = (sh == 0) ? 1 : sh; end
        6'd36: code = 3'd0;
        6'd37: code = 3'd1;
        default: begin code = 3'd3; ill = 1; end
      endcase
    end
    for (int i = 0; i < n; i++)
      q.push_back('{code: code, ill: ill, lst: (i == n - 1)});
  endtask

  task automatic check_all(string tag);
    bit v;
    v = q.size() > 0;
    chk({tag, ".valid"}, ctl_valid, v);
    chk({tag, ".busy"}, busy, v);
    chk({tag, ".code"}, alu_ctl, v ? q[0].code : 3'd0);
    chk({tag, ".last"}, last, v ? q[0].lst : 1'b0);
    chk({tag, ".illegal"}, illegal, v ? q[0].ill : 1'b0);
    chk({tag, ".ready"}, in_ready, exp_ready());
  endtask

  task automatic cycle(string tag);
    bit acc, fl;
    logic [1:0] op;
    logic [5:0] f;
    logic [4:0] sh;
    fl = flush_v;
    acc = in_valid && exp_ready() && !rst;
    op = alu_op; f = funct; sh = shamt;
    @(posedge clk);
    if (!rst) begin
      if (q.size() > 0) void'(q.pop_front());
      if (fl) q.delete();
      else if (acc) push_cmd(op, f, sh);
    end
    #1;
    check_all(tag);
  endtask

  task automatic issue(string tag, logic [1:0] op, logic [5:0] f,
                       logic [4:0] sh);
    in_valid = 1'b1;
    alu_op = op; funct = f; shamt = sh;
    cycle(tag);
    in_valid = 1'b0;
    alu_op = 2'($urandom); funct = 6'($urandom);
    shamt = 5'($urandom);
  endtask

  task automatic run(string tag, int n);
    for (int i = 0; i < n; i++) cycle(tag);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;
    run("idle", 4);

    issue("lw", 2'b00, 6'd0, 5'd0);
    run("lw_tail", 2);

    issue("rol5", 2'b10, 6'd33, 5'd5);
    run("rol5_run", 6);

    issue("ror2", 2'b10, 6'd35, 5'd2);
    in_valid = 1'b1; alu_op = 2'b01;
    run("b2b", 2);
    in_valid = 1'b0;
    run("b2b_tail", 2);

    issue("illegal", 2'b11, 6'd63, 5'd7);
    run("ill_tail", 1);
    issue("rol0", 2'b10, 6'd33, 5'd0);
    run("rol0_tail", 1);
    issue("and", 2'b10, 6'd36, 5'd9);
    issue("or", 2'b10, 6'd37, 5'd9);
    issue("add", 2'b10, 6'd32, 5'd9);
    issue("sub", 2'b10, 6'd34, 5'd9);
    run("alu_tail", 2);

    issue("rolmax", 2'b10, 6'd33, 5'd31);
    run("rolmax_run", 33);

    issue("rst_mid", 2'b10, 6'd33, 5'd31);
    run("rst_mid_run", 2);
    rst = 1'b1;
    #1;
    q.delete();
    check_all("rst_async");
    run("rst_hold", 2);
    rst = 1'b0;
    run("rst_after", 3);

`ifdef ALU_CTL_SEQ_FLUSH_EN
    issue("fl_cmd", 2'b10, 6'd33, 5'd31);
    run("fl_run", 2);
    flush_v = 1'b1;
    in_valid = 1'b1; alu_op = 2'b00;
    #1;
    check_all("fl_ready");
    cycle("fl_edge");
    flush_v = 1'b0;
    #1;
    check_all("fl_idle");
    cycle("fl_new");
    in_valid = 1'b0;
    run("fl_tail", 2);
`endif

    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom % 3) != 0;
      alu_op = 2'($urandom);
      funct = ($urandom % 2) ? 6'(32 + $urandom % 6) : 6'($urandom);
      shamt = ($urandom % 8 == 0) ? 5'($urandom) : 5'($urandom % 4);
`ifdef ALU_CTL_SEQ_FLUSH_EN
      flush_v = ($urandom % 25) == 0;
`endif
      cycle("rand");
    end
    in_valid = 1'b0;
    flush_v = 1'b0;
    run("drain", 40);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
